pixel_collector_core: RTL and testbench
=======================================

Name:
pixel_collector_core

Overview:
- Assembles a serial byte stream into fixed-width pixels.
- Buffers the pixels in a small output FIFO and presents them on a valid/ready pixel interface.
- Sits between a byte-oriented sensor/link receiver and the frame/image pipeline.
- Verified at block level using the non-synthesizable clock source nonsynth_clock_gen (cycle_time_p = 10, i.e. 10-time-unit period); that generator is bench-only and not part of this RTL.

Parameters:
- pixel_bytes_p, 2, bytes per pixel (>= 1).
- pixel_width_p, pixel_bytes_p*8, pixel width in bits; derived, not overridden.
- fifo_depth_p, 4, output FIFO entries (power of two, >= 2).

Ports:
- clk_i  in  1  single clock; all logic on its rising edge.
- reset_i  in  1  synchronous, active-high reset.
- data_i  in  8  input byte.
- valid_i  in  1  data_i is a byte this cycle; no input backpressure, byte always consumed.
- ready_i  in  1  downstream accepts pixel_o this cycle.
- valid_o  out  1  pixel_o holds a valid pixel (FIFO non-empty).
- pixel_o  out  pixel_width_p  current head pixel.
- overflow_o  out  1  sticky: a completed pixel was dropped because the FIFO was full.

Behaviour:
- Clocking and reset:
  - One clock domain; reset is synchronous and active-high.
  - While reset_i = 1: byte counter = 0, partial shift register = 0, FIFO emptied, valid_o = 0, pixel_o = 0, overflow_o = 0.
  - Reset mid-pixel discards the partial bytes.
- Byte assembly:
  - A byte is taken on each rising edge where valid_i = 1 and reset_i = 0; no other byte-acceptance condition exists.
  - Byte order is big-endian: the first byte lands in bits [pixel_width_p-1 -: 8], the last byte in [7:0].
  - The byte counter runs 0..pixel_bytes_p-1 and wraps to 0 on the final byte. The pixel boundary is defined only by this count; there is no idle timeout.
  - Gaps of any length (valid_i = 0) between bytes of one pixel are allowed; the partial state is held.
- Push:
  - When the final byte of a pixel is accepted, the full pixel is written into the FIFO on that same edge.
  - valid_o is high in the next cycle if the FIFO was empty.
  - Latency: final byte at edge N -> valid_o = 1 and pixel_o = pixel during the cycle after edge N.
- Pop:
  - Occurs on a rising edge with valid_o = 1 and ready_i = 1; the head advances.
  - Each pixel is presented exactly until the edge where it is popped. A downstream that samples on every valid_o & ready_i edge sees each pixel exactly once, in arrival order.
- Output when empty: valid_o = 0 and pixel_o = 0 (forced to zero).
- Hold: with ready_i = 0 and valid_o = 1, pixel_o stays stable.
- Full FIFO:
  - Push and pop on the same edge: both happen and the count is unchanged; allowed even when full.
  - Push with no pop: the new pixel is dropped, FIFO contents are unchanged, overflow_o goes to 1 on that edge and stays 1 until reset.
  - Byte assembly continues normally after a drop.
- Empty FIFO with simultaneous push: no pop is possible (valid_o = 0); the pixel appears next cycle.
- Occupancy: read/write pointers of log2(fifo_depth_p) bits wrap modulo depth; a separate count (or an extra pointer bit) distinguishes full from empty.
- Throughput: sustains one pixel per pixel_bytes_p cycles indefinitely with ready_i = 1 and no loss.

Test Plan:
- After reset, bytes 0x12 then 0x34 on consecutive cycles, ready_i = 1 -> one cycle after the second byte, valid_o = 1 and pixel_o = 0x1234 for exactly one cycle; then valid_o = 0, pixel_o = 0.
- 80x60 frame, 4800 pixels, 2 bytes each, valid_i pulsed one cycle per byte with gaps, ready_i = 1 -> exactly 4800 pops, in order, matching input; overflow_o = 0.
- ready_i = 0, send 0x0001..0x0004 (depth 4) -> valid_o = 1 and pixel_o held at 0x0001. Send 0x0005 -> dropped, overflow_o = 1. Raise ready_i -> outputs 0x0001..0x0004, then valid_o = 0.
- FIFO full, final byte of 0x0005 on the same edge as a pop -> no drop, overflow_o stays 0; output order 0x0002, 0x0003, 0x0004, 0x0005.
- Send 0xAB, assert reset_i for one cycle, then send 0x12, 0x34 -> only 0x1234 emitted; valid_o = 0 and overflow_o = 0 during and after reset.
- pixel_bytes_p = 3, bytes 0xAA, 0xBB, 0xCC -> pixel_o = 0xAABBCC one cycle after 0xCC.

Source files
------------

// File: rtl/pixel_collector_core.sv
// Serial byte-to-pixel assembler with a small output FIFO on a valid/ready interface.
// Bytes arrive big-endian; completed pixels that find the FIFO full are dropped and flagged.
module pixel_collector_core #(
    parameter  int pixel_bytes_p = 2,
    parameter  int fifo_depth_p  = 4,
    localparam int pixel_width_p = pixel_bytes_p * 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [7:0]               data_i,
    input  logic                     valid_i,
    input  logic                     ready_i,
    output logic                     valid_o,
    output logic [pixel_width_p-1:0] pixel_o,
    output logic                     overflow_o
);

    localparam int cnt_w   = (pixel_bytes_p > 1) ? $clog2(pixel_bytes_p) : 1;
    localparam int ptr_w   = (fifo_depth_p > 1) ? $clog2(fifo_depth_p) : 1;
    localparam int count_w = ptr_w + 1;

    localparam logic [cnt_w-1:0]   last_byte_c = cnt_w'(pixel_bytes_p - 1);
    localparam logic [count_w-1:0] depth_c     = count_w'(fifo_depth_p);

    // Byte assembly state
    logic [cnt_w-1:0]         byte_cnt_q;
    logic [pixel_width_p-1:0] shift_q;
    logic [pixel_width_p-1:0] pixel_next;
    logic                     byte_last;
    logic                     push_req;

    // FIFO state
    logic [pixel_width_p-1:0] mem_q [fifo_depth_p];
    logic [ptr_w-1:0]         wr_ptr_q;
    logic [ptr_w-1:0]         rd_ptr_q;
    logic [count_w-1:0]       count_q;
    logic                     overflow_q;

    logic fifo_empty;
    logic fifo_full;
    logic pop;
    logic push_ok;

    // Shift the new byte in at the bottom; older bytes move toward the MSBs.
    assign pixel_next = pixel_width_p'({shift_q, data_i});
    assign byte_last  = (byte_cnt_q == last_byte_c);
    assign push_req   = valid_i && byte_last;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == depth_c);
    assign pop        = !fifo_empty && ready_i;
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign push_ok    = push_req && (!fifo_full || pop);

    assign valid_o    = !fifo_empty;
    assign pixel_o    = fifo_empty ? '0 : mem_q[rd_ptr_q];
    assign overflow_o = overflow_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            byte_cnt_q <= '0;
            shift_q    <= '0;
        end else if (valid_i) begin
            if (byte_last) begin
                byte_cnt_q <= '0;
                shift_q    <= '0;
            end else begin
                byte_cnt_q <= byte_cnt_q + cnt_w'(1);
                shift_q    <= pixel_next;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + ptr_w'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + ptr_w'(1);
            end
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + count_w'(1);
                2'b01:   count_q <= count_q - count_w'(1);
                default: count_q <= count_q;
            endcase
            if (push_req && !push_ok) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // NOTE: storage is not reset; count_q gates every read, so stale entries are never visible.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= pixel_next;
        end
    end

endmodule

// File: tb/tb_pixel_collector_core.sv
// Self-checking bench: table-driven vectors plus a scoreboard-driven FIFO model.
module tb_pixel_collector_core;

    localparam int depth_c = 4;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic [7:0]  data_i;
    logic        valid_i;
    logic        ready_i;
    logic        valid_o;
    logic [15:0] pixel_o;
    logic        overflow_o;

    logic [7:0]  data3;
    logic        valid3;
    logic        ready3;
    logic        valid3_o;
    logic [23:0] pixel3_o;
    logic        overflow3_o;

    int checks   = 0;
    int failures = 0;

    pixel_collector_core #(.pixel_bytes_p(2), .fifo_depth_p(depth_c)) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .data_i    (data_i),
        .valid_i   (valid_i),
        .ready_i   (ready_i),
        .valid_o   (valid_o),
        .pixel_o   (pixel_o),
        .overflow_o(overflow_o)
    );

    pixel_collector_core #(.pixel_bytes_p(3), .fifo_depth_p(4)) dut3 (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .data_i    (data3),
        .valid_i   (valid3),
        .ready_i   (ready3),
        .valid_o   (valid3_o),
        .pixel_o   (pixel3_o),
        .overflow_o(overflow3_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard model of the pixel FIFO
    logic [15:0] exp_q[$];
    logic        exp_ovf  = 1'b0;
    logic        mon_en   = 1'b0;
    logic        pend_v   = 1'b0;
    logic [15:0] pend_pix = '0;
    int          dut_pops = 0;

    always @(negedge clk_i) begin : monitor
        bit popped;
        if (mon_en) begin
            if (reset_i) begin
                exp_q.delete();
                exp_ovf = 1'b0;
                pend_v  = 1'b0;
            end else begin
                check("sb valid_o", 32'(valid_o), 32'(exp_q.size() != 0));
                check("sb pixel_o", 32'(pixel_o), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
                check("sb overflow_o", 32'(overflow_o), 32'(exp_ovf));
                if (valid_o && ready_i) dut_pops++;
                popped = (exp_q.size() != 0) && ready_i;
                if (pend_v) begin
                    if (exp_q.size() == depth_c && !popped) exp_ovf = 1'b1;
                    else exp_q.push_back(pend_pix);
                    pend_v = 1'b0;
                end
                if (popped) void'(exp_q.pop_front());
            end
        end
    end

    // Bench-side byte tracker for the 2-byte DUT
    int          byte_idx   = 0;
    logic [15:0] tb_partial = '0;

    task automatic send_byte(input logic [7:0] d, input logic rdy);
        valid_i    = 1'b1;
        data_i     = d;
        ready_i    = rdy;
        tb_partial = {tb_partial[7:0], d};
        if (byte_idx == 1) begin
            pend_pix = tb_partial;
            pend_v   = 1'b1;
            byte_idx = 0;
        end else begin
            byte_idx = 1;
        end
        @(posedge clk_i); #1;
        valid_i = 1'b0;
    endtask

    task automatic send_pixel(input logic [15:0] p, input logic rdy);
        send_byte(p[15:8], rdy);
        send_byte(p[7:0], rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        valid_i = 1'b0;
        ready_i = rdy;
        repeat (n) begin
            @(posedge clk_i); #1;
        end
    endtask

    task automatic do_reset();
        reset_i  = 1'b1;
        valid_i  = 1'b0;
        valid3   = 1'b0;
        @(posedge clk_i); #1;
        reset_i  = 1'b0;
        byte_idx = 0;
    endtask

    typedef struct {
        logic        v;
        logic [7:0]  d;
        logic        r;
        logic        ev;
        logic [15:0] ep;
        logic        eo;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic r,
                                input logic ev, input logic [15:0] ep, input logic eo);
        vec_t t;
        t.v = v; t.d = d; t.r = r; t.ev = ev; t.ep = ep; t.eo = eo;
        return t;
    endfunction

    initial begin
        vec_t tbl[$];
        int   pops_before;
        logic [15:0] p;

        reset_i = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        data_i  = '0;
        valid3  = 1'b0;
        ready3  = 1'b1;
        data3   = '0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;

        check("reset valid_o", 32'(valid_o), 32'h0);
        check("reset pixel_o", 32'(pixel_o), 32'h0);
        check("reset overflow_o", 32'(overflow_o), 32'h0);
        check("reset dut3 valid_o", 32'(valid3_o), 32'h0);

        // Each row: inputs for one cycle, outputs expected after the consuming edge.
        tbl.push_back(mk(1, 8'h12, 1, 0, 16'h0000, 0));
        tbl.push_back(mk(1, 8'h34, 1, 1, 16'h1234, 0));
        tbl.push_back(mk(0, 8'h00, 1, 0, 16'h0000, 0));
        tbl.push_back(mk(0, 8'h00, 0, 0, 16'h0000, 0));
        for (int i = 1; i <= 4; i++) begin
            tbl.push_back(mk(1, 8'h00, 0, (i > 1), (i > 1) ? 16'h0001 : 16'h0000, 0));
            tbl.push_back(mk(1, 8'(i), 0, 1, 16'h0001, 0));
        end
        tbl.push_back(mk(1, 8'h00, 0, 1, 16'h0001, 0));
        tbl.push_back(mk(1, 8'h05, 0, 1, 16'h0001, 1));
        tbl.push_back(mk(0, 8'h00, 0, 1, 16'h0001, 1));
        tbl.push_back(mk(0, 8'h00, 1, 1, 16'h0002, 1));
        tbl.push_back(mk(0, 8'h00, 1, 1, 16'h0003, 1));
        tbl.push_back(mk(0, 8'h00, 1, 1, 16'h0004, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 16'h0000, 1));
        tbl.push_back(mk(0, 8'h00, 1, 0, 16'h0000, 1));

        foreach (tbl[i]) begin
            valid_i = tbl[i].v;
            data_i  = tbl[i].d;
            ready_i = tbl[i].r;
            @(posedge clk_i); #1;
            check($sformatf("tbl[%0d] valid_o", i), 32'(valid_o), 32'(tbl[i].ev));
            check($sformatf("tbl[%0d] pixel_o", i), 32'(pixel_o), 32'(tbl[i].ep));
            check($sformatf("tbl[%0d] overflow_o", i), 32'(overflow_o), 32'(tbl[i].eo));
        end
        valid_i = 1'b0;

        // Three-byte pixels on the second instance
        valid3 = 1'b1; data3 = 8'hAA;
        @(posedge clk_i); #1;
        check("dut3 after AA valid", 32'(valid3_o), 32'h0);
        data3 = 8'hBB;
        @(posedge clk_i); #1;
        check("dut3 after BB valid", 32'(valid3_o), 32'h0);
        data3 = 8'hCC;
        @(posedge clk_i); #1;
        valid3 = 1'b0;
        check("dut3 valid_o", 32'(valid3_o), 32'h1);
        check("dut3 pixel_o", 32'(pixel3_o), 32'h00AABBCC);
        @(posedge clk_i); #1;
        check("dut3 drained valid", 32'(valid3_o), 32'h0);
        check("dut3 drained pixel", 32'(pixel3_o), 32'h0);

        // Scoreboard phase starts from a reset so model and DUT agree.
        mon_en = 1'b1;
        do_reset();
        check("post-reset overflow_o", 32'(overflow_o), 32'h0);

        // Full FIFO, final byte of 0x0005 lands on a pop edge
        for (int i = 1; i <= 4; i++) send_pixel(16'(i), 1'b0);
        send_byte(8'h00, 1'b0);
        check("full hold pixel_o", 32'(pixel_o), 32'h0001);
        send_byte(8'h05, 1'b1);
        idle(8, 1'b1);
        check("push+pop overflow_o", 32'(overflow_o), 32'h0);
        check("push+pop drained", 32'(valid_o), 32'h0);

        // Reset mid-pixel discards the partial byte
        send_byte(8'hAB, 1'b1);
        do_reset();
        check("mid-reset valid_o", 32'(valid_o), 32'h0);
        check("mid-reset overflow_o", 32'(overflow_o), 32'h0);
        send_pixel(16'h1234, 1'b1);
        idle(4, 1'b1);
        check("mid-reset overflow after", 32'(overflow_o), 32'h0);

        // 80x60 frame with random gaps
        pops_before = dut_pops;
        for (int i = 0; i < 4800; i++) begin
            p = 16'(i * 37 + 11);
            send_byte(p[15:8], 1'b1);
            idle($urandom_range(0, 2), 1'b1);
            send_byte(p[7:0], 1'b1);
            idle($urandom_range(0, 2), 1'b1);
        end
        idle(4, 1'b1);
        check("frame pop count", 32'(dut_pops - pops_before), 32'd4800);
        check("frame overflow_o", 32'(overflow_o), 32'h0);

        // Random backpressure, back-to-back pixels: drops tracked by the model
        for (int i = 0; i < 200; i++) begin
            p = 16'($urandom);
            send_byte(p[15:8], 1'($urandom_range(0, 3) == 0));
            send_byte(p[7:0], 1'($urandom_range(0, 3) == 0));
        end
        idle(10, 1'b1);
        check("random drained", 32'(valid_o), 32'h0);

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
